// File: rtl/audio_out_if.sv
// Stereo sample handshake between the processing chain and audio_out.
// The master offers a frame with in_valid; the slave takes it when in_ready is high.
interface audio_out_if #(
   parameter int DATA_W = 16
);
   logic signed [DATA_W-1:0] in_left;
   logic signed [DATA_W-1:0] in_right;
   logic                     in_valid;
   logic                     in_ready;

   modport master (
      output in_left,
      output in_right,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_left,
      input  in_right,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/audio_out.sv
// audio_out: serialises stereo frames onto DACDAT, MSB first, framed by the
// codec's LRCLK (high = left slot). One frame can wait in a pending stage
// while the active frame is being shifted out. A left slot that starts with
// nothing pending is muted and counted as an underrun.
module audio_out #(
   parameter int DATA_W = 16
) (
   input  logic       BCLK,
   input  logic       RESET_N,
   input  logic       LRCLK,
   audio_out_if.slave bus,
   output logic       DACDAT,
   output logic       underrun,
   output logic [7:0] underrun_count
);
   localparam int                CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DATA_W);

   logic              lrclk_prev_reg;
   logic              full_reg, full_next;
   logic [DATA_W-1:0] pend_left_reg, pend_left_next;
   logic [DATA_W-1:0] pend_right_reg, pend_right_next;
   logic [DATA_W-1:0] act_left_reg, act_left_next;
   logic [DATA_W-1:0] act_right_reg, act_right_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic              dacdat_reg, dacdat_next;
   logic              underrun_reg, underrun_next;
   logic [7:0]        underrun_count_reg, underrun_count_next;

   logic              lr_edge, lr_rise, lr_fall, accept;
   logic [DATA_W-1:0] word_load;

   // The pending stage is the only thing that can refuse a frame.
   assign bus.in_ready = RESET_N & ~full_reg;
   assign accept       = bus.in_valid & RESET_N & ~full_reg;

   assign lr_edge = LRCLK ^ lrclk_prev_reg;
   assign lr_rise = lr_edge & LRCLK;
   assign lr_fall = lr_edge & ~LRCLK;

   assign DACDAT         = dacdat_reg;
   assign underrun       = underrun_reg;
   assign underrun_count = underrun_count_reg;

   // Next-state for the frame pipeline, underrun tracking and the serialiser.
   always_comb begin
      full_next           = full_reg;
      pend_left_next      = pend_left_reg;
      pend_right_next     = pend_right_reg;
      act_left_next       = act_left_reg;
      act_right_next      = act_right_reg;
      shift_next          = shift_reg;
      bit_cnt_next        = bit_cnt_reg;
      dacdat_next         = 1'b0;
      underrun_next       = 1'b0;
      underrun_count_next = underrun_count_reg;
      word_load           = '0;

      // Left slot start: promote the pending frame, or mute if there is none.
      if (lr_rise) begin
         if (full_reg) begin
            act_left_next  = pend_left_reg;
            act_right_next = pend_right_reg;
            full_next      = 1'b0;
         end else begin
            act_left_next  = '0;
            act_right_next = '0;
            underrun_next  = 1'b1;
            if (underrun_count_reg != 8'hFF)
               underrun_count_next = underrun_count_reg + 8'd1;
         end
      end

      // A frame taken on a left edge lands in pending for the following frame.
      if (accept) begin
         pend_left_next  = bus.in_left;
         pend_right_next = bus.in_right;
         full_next       = 1'b1;
      end

      // Any LRCLK edge restarts the word, aborting a truncated one.
      if (lr_edge) begin
         word_load    = lr_rise ? act_left_next : act_right_reg;
         shift_next   = word_load;
         dacdat_next  = word_load[DATA_W-1];
         bit_cnt_next = CNT_W'(1);
      end else if (bit_cnt_reg < CNT_DONE) begin
         dacdat_next  = shift_reg[DATA_W-2];
         shift_next   = {shift_reg[DATA_W-2:0], 1'b0};
         bit_cnt_next = bit_cnt_reg + CNT_W'(1);
      end
   end

   // State registers; lrclk_prev tracks LRCLK even in reset so release sees no edge.
   always_ff @(posedge BCLK) begin
      lrclk_prev_reg <= LRCLK;
      if (!RESET_N) begin
         full_reg           <= 1'b0;
         pend_left_reg      <= '0;
         pend_right_reg     <= '0;
         act_left_reg       <= '0;
         act_right_reg      <= '0;
         shift_reg          <= '0;
         bit_cnt_reg        <= CNT_DONE;
         dacdat_reg         <= 1'b0;
         underrun_reg       <= 1'b0;
         underrun_count_reg <= 8'd0;
      end else begin
         full_reg           <= full_next;
         pend_left_reg      <= pend_left_next;
         pend_right_reg     <= pend_right_next;
         act_left_reg       <= act_left_next;
         act_right_reg      <= act_right_next;
         shift_reg          <= shift_next;
         bit_cnt_reg        <= bit_cnt_next;
         dacdat_reg         <= dacdat_next;
         underrun_reg       <= underrun_next;
         underrun_count_reg <= underrun_count_next;
      end
   end
endmodule

// File: tb/tb_audio_out.sv
// Bench for audio_out: directed scenarios plus randomized traffic, every cycle
// compared against a slot-level reference model of the serial output.
module tb_audio_out;
   localparam int DATA_W = 16;

   logic       BCLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       LRCLK = 1'b0;
   logic       DACDAT;
   logic       underrun;
   logic [7:0] underrun_count;

   audio_out_if #(.DATA_W(DATA_W)) bus ();

   audio_out #(.DATA_W(DATA_W)) dut (
      .BCLK           (BCLK),
      .RESET_N        (RESET_N),
      .LRCLK          (LRCLK),
      .bus            (bus),
      .DACDAT         (DACDAT),
      .underrun       (underrun),
      .underrun_count (underrun_count)
   );

   always #5 BCLK = ~BCLK;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a slot carries one word; bit position counts from the edge.
   logic              m_full = 1'b0;
   logic [DATA_W-1:0] m_pl = '0, m_pr = '0, m_al = '0, m_ar = '0, m_word = '0;
   int                m_pos = DATA_W;
   int                m_cnt = 0;
   logic              m_prev = 1'b0;
   logic              m_und = 1'b0;
   logic              m_edge = 1'b0;
   logic              m_rise = 1'b0;
   logic              m_acc = 1'b0;
   logic              exp_dac;

   // LRCLK generator and word capture.
   int                lr_half = 32;
   int                lr_cnt = 0;
   logic [DATA_W-1:0] cap = '0;
   int                cap_n = 0;
   logic              cap_left = 1'b0;
   logic              want_left = 1'b0;
   logic              word_done = 1'b0;
   logic [DATA_W-1:0] word_val = '0;
   int                und_hi = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge BCLK);
      m_edge = 1'b0;
      m_rise = 1'b0;
      m_acc  = 1'b0;
      if (!RESET_N) begin
         m_full = 1'b0; m_pl = '0; m_pr = '0; m_al = '0; m_ar = '0; m_word = '0;
         m_pos = DATA_W; m_und = 1'b0; m_cnt = 0; m_prev = LRCLK;
      end else begin
         m_edge = (LRCLK != m_prev);
         m_prev = LRCLK;
         m_acc  = bus.in_valid && !m_full;
         m_und  = 1'b0;
         if (m_edge) begin
            if (LRCLK) begin
               m_rise = 1'b1;
               if (m_full) begin
                  m_al = m_pl; m_ar = m_pr; m_full = 1'b0;
               end else begin
                  m_al = '0; m_ar = '0; m_und = 1'b1;
                  if (m_cnt < 255) m_cnt++;
               end
               m_word = m_al;
            end else begin
               m_word = m_ar;
            end
            m_pos = 0;
         end else if (m_pos < DATA_W) begin
            m_pos++;
         end
         if (m_acc) begin
            m_pl = bus.in_left; m_pr = bus.in_right; m_full = 1'b1;
            $display("frame accepted: left=0x%04h right=0x%04h", bus.in_left, bus.in_right);
         end
      end
      #1;
      exp_dac = (m_pos < DATA_W) ? m_word[DATA_W-1-m_pos] : 1'b0;
      check("dacdat", DACDAT, exp_dac);
      check("underrun", underrun, m_und);
      check("underrun_count", underrun_count, m_cnt);
      check("in_ready", bus.in_ready, RESET_N && !m_full);
      if (underrun === 1'b1) und_hi++;
      // Reassemble whole words from the serial line, independent of the model.
      if (!RESET_N) begin
         cap_n = 0;
      end else if (m_edge) begin
         cap = '0; cap[0] = DACDAT; cap_n = 1; cap_left = LRCLK;
      end else if (cap_n > 0 && cap_n < DATA_W) begin
         cap = {cap[DATA_W-2:0], DACDAT};
         cap_n++;
         if (cap_n == DATA_W && cap_left == want_left) begin
            word_done = 1'b1;
            word_val  = cap;
         end
      end
      lr_cnt++;
      if (lr_cnt >= lr_half) begin
         lr_cnt = 0;
         LRCLK  = ~LRCLK;
      end
   endtask

   task automatic wait_accept();
      logic got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         tick();
         if (m_acc) got = 1'b1;
      end
      check("accept_wait", got, 1);
   endtask

   task automatic wait_word(input logic left, output logic [DATA_W-1:0] w);
      want_left = left;
      word_done = 1'b0;
      for (int i = 0; i < 300 && !word_done; i++) tick();
      check("word_wait", word_done, 1);
      w = word_val;
   endtask

   initial begin
      logic [DATA_W-1:0] w;
      logic [DATA_W-1:0] b_left, b_right;
      logic              seen;

      bus.in_left  = '0;
      bus.in_right = '0;
      bus.in_valid = 1'b0;

      // Reset state.
      repeat (3) tick();
      check("rst_dacdat", DACDAT, 0);
      check("rst_underrun", underrun, 0);
      check("rst_count", underrun_count, 0);
      check("rst_ready", bus.in_ready, 0);
      RESET_N = 1'b1;

      // Basic frame: left 8001, right 7FFE.
      bus.in_left  = 16'sh8001;
      bus.in_right = 16'sh7FFE;
      bus.in_valid = 1'b1;
      wait_accept();
      bus.in_valid = 1'b0;
      check("ready_after_accept", bus.in_ready, 0);
      wait_word(1'b1, w);
      check("basic_left", w, 16'h8001);
      wait_word(1'b0, w);
      check("basic_right", w, 16'h7FFE);

      // Underrun: nothing offered across the next left edge.
      und_hi = 0;
      wait_word(1'b1, w);
      check("underrun_left", w, 0);
      check("underrun_count_1", underrun_count, 1);
      check("underrun_width", und_hi, 1);
      wait_word(1'b0, w);
      check("underrun_right", w, 0);

      // Pending full when frame A is offered across a left edge.
      b_left  = DATA_W'($urandom);
      b_right = DATA_W'($urandom);
      bus.in_left  = b_left;
      bus.in_right = b_right;
      bus.in_valid = 1'b1;
      wait_accept();
      bus.in_left  = 16'sh1234;
      bus.in_right = 16'sh0F0F;
      wait_word(1'b1, w);
      check("held_old_left", w, b_left);
      wait_word(1'b0, w);
      check("held_old_right", w, b_right);
      bus.in_valid = 1'b0;
      wait_word(1'b1, w);
      check("held_a_left", w, 16'h1234);
      wait_word(1'b0, w);
      check("held_a_right", w, 16'h0F0F);

      // Short slots truncate words; model checks the new MSB on each edge.
      lr_half = 8;
      for (int i = 0; i < 200; i++) begin
         bus.in_valid = ($urandom_range(0, 3) == 0);
         bus.in_left  = DATA_W'($urandom);
         bus.in_right = DATA_W'($urandom);
         tick();
      end

      // Reset pulse at bit 5 of a left word.
      lr_half = 32;
      bus.in_left  = 16'shFFFF;
      bus.in_right = 16'shFFFF;
      bus.in_valid = 1'b1;
      wait_accept();
      bus.in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         tick();
         if (m_rise) seen = 1'b1;
      end
      check("rise_wait", seen, 1);
      repeat (5) tick();
      RESET_N = 1'b0;
      tick();
      check("midreset_dacdat", DACDAT, 0);
      RESET_N = 1'b1;
      tick();
      check("midreset_ready", bus.in_ready, 1);
      check("midreset_dacdat_after", DACDAT, 0);

      // Randomized traffic with varying slot lengths and occasional reset.
      for (int i = 0; i < 1200; i++) begin
         if (i % 300 == 0) lr_half = $urandom_range(6, 40);
         bus.in_valid = ($urandom_range(0, 1) == 0);
         bus.in_left  = DATA_W'($urandom);
         bus.in_right = DATA_W'($urandom);
         RESET_N      = ($urandom_range(0, 249) != 0);
         tick();
      end
      RESET_N = 1'b1;

      // Saturation: more than 300 consecutive underruns.
      bus.in_valid = 1'b0;
      lr_half = 2;
      repeat (1300) tick();
      check("count_saturated", underrun_count, 255);
      repeat (20) tick();
      check("count_holds", underrun_count, 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
